// File: rtl/float_pkg.sv
// -----------------------------------------------------------------------------
// float_pkg
//   Shared IEEE-754 single-precision helpers for the neural datapath blocks
//   and their benches: field widths, field slice positions, NaN/zero
//   classification and sign/magnitude extraction. Also carries the state
//   encoding of the argmax scanner.
// -----------------------------------------------------------------------------
package float_pkg;

  localparam int FLOAT_W = 32;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Field slice positions inside a FLOAT_W word.
  localparam int SIGN_BIT = FLOAT_W - 1;
  localparam int EXP_LSB  = MANT_W;
  localparam int MANT_LSB = 0;
  localparam int MAG_W    = FLOAT_W - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } argmax_state_e;

  // NaN: all-ones exponent with a non-zero mantissa (inf has mantissa 0).
  function automatic logic is_nan(input logic [FLOAT_W-1:0] x);
    return (x[EXP_LSB +: EXP_W] == EXP_MAX) && (x[MANT_LSB +: MANT_W] != '0);
  endfunction

  // +0 and -0 both count as zero.
  function automatic logic is_zero(input logic [FLOAT_W-1:0] x);
    return (x[MAG_W-1:0] == '0);
  endfunction

  function automatic logic sign_of(input logic [FLOAT_W-1:0] x);
    return x[SIGN_BIT];
  endfunction

  // Exponent and mantissa together order a same-signed float by magnitude,
  // denormals included.
  function automatic logic [MAG_W-1:0] mag_of(input logic [FLOAT_W-1:0] x);
    return x[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/float_greater.sv
// -----------------------------------------------------------------------------
// float_greater
//   Combinational signed IEEE-754 single "a > b" comparator.
//   Ports:
//     a, b    [31:0] operand bit patterns
//     a_gt_b          1 when a is strictly greater than b
//   Ordering: -inf < negatives < -0 == +0 < positives < +inf. Any NaN
//   operand yields 0, so callers decide how NaN is handled.
// -----------------------------------------------------------------------------
module float_greater
  import float_pkg::*;
(
  input  logic [FLOAT_W-1:0] a,
  input  logic [FLOAT_W-1:0] b,
  output logic               a_gt_b
);

  logic             sign_a;
  logic             sign_b;
  logic [MAG_W-1:0] mag_a;
  logic [MAG_W-1:0] mag_b;

  assign sign_a = sign_of(a);
  assign sign_b = sign_of(b);
  assign mag_a  = mag_of(a);
  assign mag_b  = mag_of(b);

  always_comb begin
    a_gt_b = 1'b0;
    if (is_nan(a) || is_nan(b)) begin
      a_gt_b = 1'b0;
    end else if (is_zero(a) && is_zero(b)) begin
      // -0 and +0 are equal, whichever sign bit each carries.
      a_gt_b = 1'b0;
    end else if (sign_a != sign_b) begin
      // Mixed signs with at least one non-zero: the positive one wins.
      a_gt_b = ~sign_a;
    end else if (!sign_a) begin
      a_gt_b = (mag_a > mag_b);
    end else begin
      // Both negative: smaller magnitude is the larger value.
      a_gt_b = (mag_a < mag_b);
    end
  end

endmodule

// File: rtl/neural_argmax.sv
// -----------------------------------------------------------------------------
// neural_argmax
//   Sequential argmax over a packed float32 vector, one element per clock
//   through a single float comparator.
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     start      request a scan (sampled only while idle)
//     in         SIZE packed float32 elements, element i at [32*i +: 32]
//     busy       high while scanning
//     done       one-cycle pulse when index/max_value/all_nan update
//     index      position of the largest element (lowest index on ties)
//     max_value  bit pattern of the largest element
//     all_nan    every element of the last scan was NaN
//   start copies the whole vector into a snapshot so the scan is immune to
//   later changes on `in`. Results hold until the next completion.
// -----------------------------------------------------------------------------
module neural_argmax
  import float_pkg::*;
#(
  parameter int SIZE  = 5,
  parameter int IDX_W = ($clog2(SIZE) > 0 ? $clog2(SIZE) : 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [FLOAT_W*SIZE-1:0] in,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        index,
  output logic [FLOAT_W-1:0]      max_value,
  output logic                    all_nan
);

  argmax_state_e state_q;
  argmax_state_e state_d;

  logic [FLOAT_W*SIZE-1:0] snap_q;
  logic [FLOAT_W-1:0]      best_q;
  logic [IDX_W-1:0]        best_idx_q;
  logic [IDX_W-1:0]        cnt_q;

  logic                    accept;
  logic                    scanning;
  logic                    last_step;
  logic [FLOAT_W-1:0]      cand;
  logic                    cand_gt;
  logic                    take;
  logic [FLOAT_W-1:0]      best_d;
  logic [IDX_W-1:0]        best_idx_d;

  assign accept    = (state_q == ST_IDLE) && start;
  assign scanning  = (state_q == ST_SCAN);
  assign last_step = (cnt_q == IDX_W'(SIZE - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic. A single-element vector resolves on the start
  // edge itself, so it never enters SCAN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start && (SIZE > 1)) state_d = ST_SCAN;
      ST_SCAN: if (last_step)           state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      ST_SCAN: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Candidate select and compare
  // ---------------------------------------------------------------------------
  always_comb begin
    cand = '0;
    for (int k = 0; k < SIZE; k++) begin
      if (cnt_q == IDX_W'(k)) cand = snap_q[FLOAT_W*k +: FLOAT_W];
    end
  end

  float_greater u_cmp (
    .a      (cand),
    .b      (best_q),
    .a_gt_b (cand_gt)
  );

  // A NaN best is displaced by the first real number; a NaN candidate never
  // wins. Strict greater-than keeps the earliest element on ties.
  assign take       = !is_nan(cand) && (is_nan(best_q) || cand_gt);
  assign best_d     = take ? cand  : best_q;
  assign best_idx_d = take ? cnt_q : best_idx_q;

  // ---------------------------------------------------------------------------
  // Snapshot, running best and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q     <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      done       <= 1'b0;
      index      <= '0;
      max_value  <= '0;
      all_nan    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        snap_q     <= in;
        best_q     <= in[FLOAT_W-1:0];
        best_idx_q <= '0;
        cnt_q      <= IDX_W'(1);
        if (SIZE == 1) begin
          index     <= '0;
          max_value <= in[FLOAT_W-1:0];
          all_nan   <= is_nan(in[FLOAT_W-1:0]);
          done      <= 1'b1;
        end
      end else if (scanning) begin
        best_q     <= best_d;
        best_idx_q <= best_idx_d;
        cnt_q      <= cnt_q + IDX_W'(1);
        // The last compare publishes straight from the comparator path; a
        // surviving NaN best means nothing numeric was seen.
        if (last_step) begin
          index     <= best_idx_d;
          max_value <= best_d;
          all_nan   <= is_nan(best_d);
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_neural_argmax.sv
// -----------------------------------------------------------------------------
// tb_neural_argmax
//   Scoreboard bench: stimulus pushes the hand-computed result and the cycle
//   at which done must appear; per-DUT monitors pop and compare on done.
//   Covers a SIZE=5 instance and a SIZE=1 instance.
// -----------------------------------------------------------------------------
module tb_neural_argmax;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start5, start1;
  logic [159:0] in5;
  logic [31:0]  in1;

  logic         busy5, done5, all_nan5;
  logic [2:0]   index5;
  logic [31:0]  max_value5;
  logic         busy1, done1, all_nan1;
  logic [0:0]   index1;
  logic [31:0]  max_value1;

  always #5 clk = ~clk;

  neural_argmax #(.SIZE(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .in(in5),
    .busy(busy5), .done(done5), .index(index5),
    .max_value(max_value5), .all_nan(all_nan5)
  );

  neural_argmax #(.SIZE(1), .IDX_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in(in1),
    .busy(busy1), .done(done1), .index(index1),
    .max_value(max_value1), .all_nan(all_nan1)
  );

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] val;
    logic        nan;
    int          at;
  } exp_t;

  exp_t q5[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy1_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [159:0] pack5(input logic [31:0] e0, input logic [31:0] e1,
                                         input logic [31:0] e2, input logic [31:0] e3,
                                         input logic [31:0] e4);
    return {e4, e3, e2, e1, e0};
  endfunction

  // Monitor for the SIZE=5 instance.
  logic prev_done5 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_done5 = 1'b0;
    end else begin
      if (done5) begin
        chk("done5_width", {31'd0, prev_done5}, 32'd0);
        chk("done5_expected", 32'(q5.size() != 0), 32'd1);
        if (q5.size() != 0) begin
          e = q5.pop_front();
          chk("index5", 32'(index5), 32'(e.idx));
          chk("max_value5", max_value5, e.val);
          chk("all_nan5", 32'(all_nan5), 32'(e.nan));
          chk("latency5", 32'(cyc), 32'(e.at));
        end
      end
      prev_done5 = done5;
    end
  end

  // Monitor for the SIZE=1 instance (back-to-back dones are legal here).
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy1) busy1_seen++;
      if (done1) begin
        chk("done1_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("index1", 32'(index1), 32'(e.idx));
          chk("max_value1", max_value1, e.val);
          chk("all_nan1", 32'(all_nan1), 32'(e.nan));
          chk("latency1", 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  // Called at a negedge: raise start and register the expected result.
  task automatic issue5(input logic [159:0] v, input logic [2:0] idx,
                        input logic [31:0] val, input logic nan);
    exp_t e;
    in5    = v;
    start5 = 1'b1;
    e.idx = idx; e.val = val; e.nan = nan; e.at = cyc + 5;
    q5.push_back(e);
  endtask

  // Drops start after the accepting edge, checks busy through the scan and
  // returns on the negedge where done must be visible. Optionally rewrites
  // element 4 to +inf mid-scan.
  task automatic track5(input logic corrupt);
    @(negedge clk);
    start5 = 1'b0;
    if (corrupt) in5[4*32 +: 32] = 32'h7F800000;
    chk("busy5_scan", 32'(busy5), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("busy5_scan", 32'(busy5), 32'd1);
    end
    @(negedge clk);
    chk("busy5_end", 32'(busy5), 32'd0);
  endtask

  task automatic push1(input logic [31:0] val, input logic nan);
    exp_t e;
    e.idx = 3'd0; e.val = val; e.nan = nan; e.at = cyc + 1;
    q1.push_back(e);
  endtask

  initial begin
    rst_n  = 1'b0;
    start5 = 1'b0;
    start1 = 1'b0;
    in5    = '0;
    in1    = '0;
    repeat (2) @(negedge clk);

    chk("rst_busy5", 32'(busy5), 32'd0);
    chk("rst_done5", 32'(done5), 32'd0);
    chk("rst_index5", 32'(index5), 32'd0);
    chk("rst_max_value5", max_value5, 32'd0);
    chk("rst_all_nan5", 32'(all_nan5), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_max_value1", max_value1, 32'd0);

    rst_n = 1'b1;
    @(negedge clk);

    // 1, 2, -1, 3, 0.5
    issue5(pack5(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h40400000, 32'h3F000000),
           3'd3, 32'h40400000, 1'b0);
    track5(1'b0);
    @(negedge clk);
    chk("done5_cleared", 32'(done5), 32'd0);
    chk("hold_index5", 32'(index5), 32'd3);

    // Ties: first 3.0 wins.
    issue5(pack5(32'h40000000, 32'h40400000, 32'h3F800000, 32'h40400000, 32'h40400000),
           3'd1, 32'h40400000, 1'b0);
    track5(1'b0);
    @(negedge clk);

    // -0 vs +0 tie keeps element 0's pattern.
    issue5(pack5(32'h80000000, 32'h00000000, 32'hBF800000, 32'hBF800000, 32'hBF800000),
           3'd0, 32'h80000000, 1'b0);
    track5(1'b0);
    @(negedge clk);

    // Leading NaN replaced, +inf wins.
    issue5(pack5(32'h7FC00000, 32'hBF800000, 32'h7F800000, 32'h7FC00000, 32'h40000000),
           3'd2, 32'h7F800000, 1'b0);
    track5(1'b0);
    @(negedge clk);

    // All NaN.
    issue5(pack5(32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000),
           3'd0, 32'h7FC00000, 1'b1);
    track5(1'b0);
    @(negedge clk);

    // All NaN with mixed patterns: element 0's pattern is reported.
    issue5(pack5(32'hFF800001, 32'h7FC00000, 32'h7FC00000, 32'hFFFFFFFF, 32'h7F800001),
           3'd0, 32'hFF800001, 1'b1);
    track5(1'b0);
    @(negedge clk);

    // Denormals of both signs around zero.
    issue5(pack5(32'h80000001, 32'h80000002, 32'h00000001, 32'h00000002, 32'h00000000),
           3'd3, 32'h00000002, 1'b0);
    track5(1'b0);
    @(negedge clk);

    // -inf, -2, -1, -inf, -100
    issue5(pack5(32'hFF800000, 32'hC0000000, 32'hBF800000, 32'hFF800000, 32'hC2C80000),
           3'd2, 32'hBF800000, 1'b0);
    track5(1'b0);
    @(negedge clk);

    // Snapshot isolation: element 4 becomes +inf during the scan.
    issue5(pack5(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h40400000, 32'h3F000000),
           3'd3, 32'h40400000, 1'b0);
    track5(1'b1);
    @(negedge clk);

    // start held through the scan: exactly one done.
    issue5(pack5(32'h40000000, 32'h40400000, 32'h3F800000, 32'h40400000, 32'h40400000),
           3'd1, 32'h40400000, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("busy5_held", 32'(busy5), 32'd1);
    end
    @(negedge clk);
    start5 = 1'b0;
    chk("busy5_held", 32'(busy5), 32'd1);
    @(negedge clk);
    chk("busy5_held_end", 32'(busy5), 32'd0);
    repeat (8) @(negedge clk);

    // Restart accepted in the done cycle.
    issue5(pack5(32'h7FC00000, 32'hBF800000, 32'h7F800000, 32'h7FC00000, 32'h40000000),
           3'd2, 32'h7F800000, 1'b0);
    track5(1'b0);
    issue5(pack5(32'h80000001, 32'h80000002, 32'h00000001, 32'h00000002, 32'h00000000),
           3'd3, 32'h00000002, 1'b0);
    track5(1'b0);
    @(negedge clk);

    // Reset during the second scan cycle: no done afterwards.
    issue5(pack5(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h40400000, 32'h3F000000),
           3'd3, 32'h40400000, 1'b0);
    @(negedge clk);
    start5 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    q5.delete();
    #1;
    chk("abort_busy5", 32'(busy5), 32'd0);
    chk("abort_done5", 32'(done5), 32'd0);
    chk("abort_index5", 32'(index5), 32'd0);
    chk("abort_max_value5", max_value5, 32'd0);
    chk("abort_all_nan5", 32'(all_nan5), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done_index5", 32'(index5), 32'd0);

    issue5(pack5(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h40400000, 32'h3F000000),
           3'd3, 32'h40400000, 1'b0);
    track5(1'b0);
    @(negedge clk);

    // SIZE=1: resolves on the start edge, never busy.
    in1    = 32'hC2C80000;
    start1 = 1'b1;
    push1(32'hC2C80000, 1'b0);
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("done1_cleared", 32'(done1), 32'd0);
    chk("hold_max_value1", max_value1, 32'hC2C80000);

    // SIZE=1 back-to-back: NaN then 1.0 on consecutive edges.
    in1    = 32'h7FC00000;
    start1 = 1'b1;
    push1(32'h7FC00000, 1'b1);
    @(negedge clk);
    in1 = 32'h3F800000;
    push1(32'h3F800000, 1'b0);
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);

    chk("q5_drained", 32'(q5.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("busy1_never", 32'(busy1_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neural_argmax.md
Name: neural_argmax

Overview:
- Sequential classifier stage directly downstream of the final neural layer.
- Consumes the packed float32 output vector `result` (activation applied) and produces the index and value of the largest element.
- Scans one element per clock with a single float comparator, so SIZE-wide output layers need no comparator tree.
- Start/done handshake lets the network testbench or a controller trigger classification once the layer output has settled.

Parameters:
- SIZE, 5, number of float32 elements in the input vector (L3); legal range ≥1.
- IDX_W, ($clog2(SIZE) > 0 ? $clog2(SIZE) : 1), width of the index output.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a scan; sampled only in IDLE.
- in  in  32*SIZE  packed IEEE-754 single vector; element i at [32*i +: 32].
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse when index/max_value are updated.
- index  out  IDX_W  index of the maximum element.
- max_value  out  32  bit pattern of the maximum element.
- all_nan  out  1  every element of the last scan was NaN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, index=0, max_value=0, all_nan=0.
  - Internal counter and snapshot are cleared.
- States: IDLE and SCAN only.
- IDLE, start=1 at edge E:
  - Snapshot all of `in` into an internal register.
  - best=elem0, best_idx=0, i=1.
  - If SIZE==1: update outputs and set done=1 at edge E, then stay in IDLE.
  - Otherwise go to SCAN with busy=1.
- SCAN, each edge: compare snapshot element i against best.
  - Replace best/best_idx if the candidate is not NaN and (best is NaN or candidate > best).
  - i increments.
  - When i==SIZE-1, the final compare result goes directly to index/max_value/all_nan, done<=1, busy<=0, state<=IDLE.
- Latency:
  - done is high in the cycle after edge E+(SIZE-1).
  - Example, SIZE=5: start sampled at edge 0, done visible after edge 4, cleared after edge 5.
- done:
  - Asserted for exactly one cycle, then returns to 0 unless a new SIZE==1 scan completes.
- Output hold:
  - index, max_value and all_nan hold until the next completion; they are never altered mid-scan.
- start handling:
  - start while busy is ignored; no queuing.
  - start in the cycle done is high is accepted, since the state is already IDLE.
- Snapshot isolation:
  - Changes on `in` during SCAN have no effect on the result.
- Float ordering, signed IEEE-754 comparison:
  - -inf < negatives < -0 == +0 < positives < +inf.
  - Denormals are ordered by their bit pattern within the sign.
- Ties, including -0 vs +0: the lowest index wins; the pattern of the earliest element is kept.
- NaN (exp=0xFF, mantissa≠0):
  - Never compares greater; it is replaced by the first non-NaN element.
  - If all elements are NaN: index=0, max_value=elem0 pattern, all_nan=1; otherwise all_nan=0.
- Reset mid-scan: abort immediately, all outputs to reset values, no done pulse.

Decomposition:
- Shared package float_pkg:
  - FLOAT_W=32, EXP_W=8, MANT_W=23, EXP_MAX=8'hFF.
  - Field slice constants.
  - is_nan / is_zero helper functions, also usable by NeuralLayer and DisplayFloat benches.
- One sub-module: float_greater (combinational).
  - Inputs a, b [31:0]; output a_gt_b.
  - Signed-magnitude compare with ±0 equal.
  - Returns 0 if either operand is NaN.
  - neural_argmax adds the NaN-replacement rule around it.

Test Plan:
- SIZE=5, in={3F800000,40000000,BF800000,40400000,3F000000} (1,2,-1,3,0.5), start pulse -> busy 4 cycles, done one cycle after edge 4, index=3, max_value=40400000, all_nan=0.
- Ties {40000000,40400000,3F800000,40400000,40400000} -> index=1, value 40400000. Zeros {80000000,00000000,BF800000,BF800000,BF800000} -> index=0, max_value=80000000.
- NaN/inf {7FC00000,BF800000,7F800000,7FC00000,40000000} -> index=2, max_value=7F800000, all_nan=0. All elements 7FC00000 -> index=0, max_value=7FC00000, all_nan=1.
- Change `in` to make elem4=7F800000 during SCAN -> result reflects the snapshot only. start held high through SCAN -> single done; a restart accepted in the done cycle yields a second done SIZE cycles later.
- Assert rst_n=0 at cycle 2 of a scan -> busy, done, index, max_value immediately 0; no done pulse after release. New start then completes normally.
- SIZE=1, IDX_W=1, in=C2C80000 (-100), start at edge 0 -> done visible after edge 0, index=0, max_value=C2C80000, busy never 1.
